tx_link_ctrl: RTL and testbench

Transmit-side link sequencer that drives the control and data inputs of the transmitter block: TXDATA, TXDATAK, TXCOMP, TXIDLE, RXDET and RXLOOPB.
- Brings the lane out of electrical idle, runs receiver detection, sends a comma training burst, then forwards user symbols through a valid/ready handshake.
- Handles compliance-pattern and loopback modes.
- Sits between link/user logic and the transmitter, in the TXCLK domain.

---
 rtl/tx_link_ctrl_if.sv | 11 +
 rtl/tx_link_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_tx_link_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tx_link_ctrl_if.sv
// User symbol stream into the transmit link sequencer: 8-bit symbol plus K flag,
// moved by a valid/ready handshake.
interface tx_link_ctrl_if;
    logic [7:0] S_DATA;
    logic       S_K;
    logic       S_VALID;
    logic       S_READY;

    modport master (output S_DATA, output S_K, output S_VALID, input S_READY);
    modport slave  (input S_DATA, input S_K, input S_VALID, output S_READY);
endinterface

// File: rtl/tx_link_ctrl.sv
// Transmit link sequencer: idle exit, receiver detect, comma training, then user data,
// with loopback and compliance modes. Optional skip insertion under SKP_INSERT_EN.
module tx_link_ctrl #(
    parameter int         DET_PULSE   = 4,
    parameter int         DET_TIMEOUT = 16,
    parameter int         TS_COUNT    = 16,
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter logic [7:0] IDLE_SYM    = 8'h7C
`ifdef SKP_INSERT_EN
    ,
    parameter logic [7:0] SKP_SYM      = 8'h1C,
    parameter int         SKP_INTERVAL = 64
`endif
) (
    input  logic                 TXCLK,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic                 COMP_REQ,
    input  logic                 LOOPB_REQ,
    input  logic                 RXDET_O,
    tx_link_ctrl_if.slave        s_if,
    output logic [7:0]           TXDATA,
    output logic                 TXDATAK,
    output logic                 TXCOMP,
    output logic                 TXIDLE,
    output logic                 RXDET,
    output logic                 RXLOOPB,
    output logic                 LINK_UP,
    output logic                 DET_FAIL,
    output logic [2:0]           STATE
);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_DETECT     = 3'd1,
        ST_DET_WAIT   = 3'd2,
        ST_TRAIN      = 3'd3,
        ST_ACTIVE     = 3'd4,
        ST_LOOPBACK   = 3'd5,
        ST_COMPLIANCE = 3'd6,
        ST_FAIL       = 3'd7
    } state_t;

    localparam logic [15:0] DET_LAST   = 16'(DET_PULSE - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(DET_TIMEOUT - 1);
    localparam logic [15:0] TRAIN_LAST = 16'(TS_COUNT - 1);
    localparam logic [7:0]  COMP_ALT   = 8'hB5;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        comp_phase_reg, comp_phase_next;

    logic [7:0]  txdata_reg, txdata_next;
    logic        txdatak_reg, txdatak_next;
    logic        txcomp_reg, txcomp_next;
    logic        txidle_reg, txidle_next;
    logic        rxdet_reg, rxdet_next;
    logic        rxloopb_reg, rxloopb_next;
    logic        link_up_reg, link_up_next;
    logic        det_fail_reg, det_fail_next;

    logic        skip_now;
    logic        s_ready;
    logic        accept;

`ifdef SKP_INSERT_EN
    localparam logic [15:0] SKP_LAST = 16'(SKP_INTERVAL - 1);
    logic [15:0] skp_cnt_reg, skp_cnt_next;

    // Runs only while ACTIVE, freezes across LOOPBACK, restarts from any other state.
    always_comb begin
        skp_cnt_next = 16'd0;
        if (state_reg == ST_ACTIVE)
            skp_cnt_next = (skp_cnt_reg == SKP_LAST) ? 16'd0 : skp_cnt_reg + 16'd1;
        else if (state_reg == ST_LOOPBACK)
            skp_cnt_next = skp_cnt_reg;
    end

    always_ff @(posedge TXCLK or negedge RESET_N) begin
        if (!RESET_N) skp_cnt_reg <= 16'd0;
        else          skp_cnt_reg <= skp_cnt_next;
    end

    assign skip_now = (state_reg == ST_ACTIVE) && (skp_cnt_reg == SKP_LAST);
`else
    assign skip_now = 1'b0;
`endif

    assign s_ready     = (state_reg == ST_ACTIVE) && !skip_now;
    assign accept      = s_ready && s_if.S_VALID;
    assign s_if.S_READY = s_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_OFF:      if (ENABLE) state_next = ST_DETECT;
            ST_DETECT:   if (cnt_reg == DET_LAST) state_next = ST_DET_WAIT;
            ST_DET_WAIT: begin
                // Detection wins even on the timeout cycle.
                if (RXDET_O)
                    state_next = ST_TRAIN;
                else if (cnt_reg == WAIT_LAST)
                    state_next = COMP_REQ ? ST_COMPLIANCE : ST_FAIL;
            end
            ST_TRAIN:    if (cnt_reg == TRAIN_LAST) state_next = ST_ACTIVE;
            ST_ACTIVE:   if (LOOPB_REQ) state_next = ST_LOOPBACK;
            ST_LOOPBACK: if (!LOOPB_REQ) state_next = ST_ACTIVE;
            default:     state_next = state_reg;
        endcase
        if (!ENABLE)
            state_next = ST_OFF;

        if (state_next != state_reg)
            cnt_next = 16'd0;
        else
            cnt_next = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

        comp_phase_next = (state_reg == ST_COMPLIANCE && state_next == ST_COMPLIANCE)
                          ? ~comp_phase_reg : 1'b0;
    end

    // Outputs are a registered function of the current state, so they trail STATE by one edge.
    always_comb begin
        txdata_next   = 8'h00;
        txdatak_next  = 1'b0;
        txcomp_next   = 1'b0;
        txidle_next   = 1'b1;
        rxdet_next    = 1'b0;
        rxloopb_next  = 1'b0;
        link_up_next  = 1'b0;
        det_fail_next = 1'b0;
        case (state_reg)
            ST_DETECT: rxdet_next = 1'b1;
            ST_TRAIN: begin
                txidle_next  = 1'b0;
                txdata_next  = COMMA;
                txdatak_next = 1'b1;
            end
            ST_ACTIVE: begin
                txidle_next  = 1'b0;
                link_up_next = 1'b1;
                if (skip_now) begin
`ifdef SKP_INSERT_EN
                    txdata_next  = SKP_SYM;
`else
                    txdata_next  = IDLE_SYM;
`endif
                    txdatak_next = 1'b1;
                end else if (accept) begin
                    txdata_next  = s_if.S_DATA;
                    txdatak_next = s_if.S_K;
                end else begin
                    txdata_next  = IDLE_SYM;
                    txdatak_next = 1'b1;
                end
            end
            ST_LOOPBACK: begin
                txidle_next  = 1'b0;
                link_up_next = 1'b1;
                rxloopb_next = 1'b1;
                txdata_next  = IDLE_SYM;
                txdatak_next = 1'b1;
            end
            ST_COMPLIANCE: begin
                txidle_next  = 1'b0;
                txcomp_next  = 1'b1;
                txdata_next  = comp_phase_reg ? COMP_ALT : COMMA;
                txdatak_next = ~comp_phase_reg;
            end
            ST_FAIL: det_fail_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge TXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= ST_OFF;
            cnt_reg        <= 16'd0;
            comp_phase_reg <= 1'b0;
            txdata_reg     <= 8'h00;
            txdatak_reg    <= 1'b0;
            txcomp_reg     <= 1'b0;
            txidle_reg     <= 1'b1;
            rxdet_reg      <= 1'b0;
            rxloopb_reg    <= 1'b0;
            link_up_reg    <= 1'b0;
            det_fail_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            comp_phase_reg <= comp_phase_next;
            txdata_reg     <= txdata_next;
            txdatak_reg    <= txdatak_next;
            txcomp_reg     <= txcomp_next;
            txidle_reg     <= txidle_next;
            rxdet_reg      <= rxdet_next;
            rxloopb_reg    <= rxloopb_next;
            link_up_reg    <= link_up_next;
            det_fail_reg   <= det_fail_next;
        end
    end

    assign TXDATA   = txdata_reg;
    assign TXDATAK  = txdatak_reg;
    assign TXCOMP   = txcomp_reg;
    assign TXIDLE   = txidle_reg;
    assign RXDET    = rxdet_reg;
    assign RXLOOPB  = rxloopb_reg;
    assign LINK_UP  = link_up_reg;
    assign DET_FAIL = det_fail_reg;
    assign STATE    = state_reg;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed bench for tx_link_ctrl: bring-up, data path, loopback, fail/compliance,
// enable drop and async reset; skip insertion is exercised when SKP_INSERT_EN is defined.
module tb_tx_link_ctrl;

    logic       TXCLK;
    logic       RESET_N;
    logic       ENABLE;
    logic       COMP_REQ;
    logic       LOOPB_REQ;
    logic       RXDET_O;
    logic [7:0] TXDATA;
    logic       TXDATAK;
    logic       TXCOMP;
    logic       TXIDLE;
    logic       RXDET;
    logic       RXLOOPB;
    logic       LINK_UP;
    logic       DET_FAIL;
    logic [2:0] STATE;

    int errors = 0;
    int checks = 0;

    tx_link_ctrl_if sif ();

    tx_link_ctrl dut (
        .TXCLK     (TXCLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .COMP_REQ  (COMP_REQ),
        .LOOPB_REQ (LOOPB_REQ),
        .RXDET_O   (RXDET_O),
        .s_if      (sif.slave),
        .TXDATA    (TXDATA),
        .TXDATAK   (TXDATAK),
        .TXCOMP    (TXCOMP),
        .TXIDLE    (TXIDLE),
        .RXDET     (RXDET),
        .RXLOOPB   (RXLOOPB),
        .LINK_UP   (LINK_UP),
        .DET_FAIL  (DET_FAIL),
        .STATE     (STATE)
    );

    initial TXCLK = 1'b0;
    always #5 TXCLK = ~TXCLK;

    task automatic step();
        @(posedge TXCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a detect-and-train sequence from OFF with bounded waits.
    task automatic bring_up(output int n_rxdet, output int n_comma);
        n_rxdet = 0;
        n_comma = 0;
        ENABLE  = 1'b1;
        RXDET_O = 1'b1;
        step();
        for (int i = 0; i < 30 && STATE != 3'd3; i++) begin
            step();
            if (RXDET) n_rxdet++;
        end
        for (int i = 0; i < 40 && !LINK_UP; i++) begin
            step();
            if (TXDATA == 8'hBC && TXDATAK) n_comma++;
        end
    endtask

    initial begin
        int n_rxdet;
        int n_comma;
        int n_lo;

        RESET_N = 1'b1; ENABLE = 1'b0; COMP_REQ = 1'b0; LOOPB_REQ = 1'b0; RXDET_O = 1'b0;
        sif.S_DATA = 8'h00; sif.S_K = 1'b0; sif.S_VALID = 1'b0;
        #3 RESET_N = 1'b0;
        #1;
        chk("rst_state",   32'(STATE),   32'd0);
        chk("rst_txidle",  32'(TXIDLE),  32'd1);
        chk("rst_txdata",  32'(TXDATA),  32'h00);
        chk("rst_sready",  32'(sif.S_READY), 32'd0);
        chk("rst_linkup",  32'(LINK_UP), 32'd0);
        chk("rst_rxdet",   32'(RXDET),   32'd0);
        step(); step();
        RESET_N = 1'b1;
        step();
        chk("off_hold", 32'(STATE), 32'd0);

        // Bring-up: 4 detect cycles, 16 commas, then ACTIVE.
        bring_up(n_rxdet, n_comma);
        chk("rxdet_cycles", 32'(n_rxdet), 32'd4);
        chk("comma_count",  32'(n_comma), 32'd16);
        chk("up_state",     32'(STATE),   32'd4);
        chk("up_linkup",    32'(LINK_UP), 32'd1);
        chk("up_idle_sym",  32'(TXDATA),  32'h7C);
        chk("up_idle_k",    32'(TXDATAK), 32'd1);
        chk("up_sready",    32'(sif.S_READY), 32'd1);
        chk("up_txidle",    32'(TXIDLE),  32'd0);

        // Back-to-back user symbols, then idle fill.
        sif.S_VALID = 1'b1; sif.S_DATA = 8'h3C; sif.S_K = 1'b0;
        step();
        chk("d0_data", 32'(TXDATA), 32'h3C);
        chk("d0_k",    32'(TXDATAK), 32'd0);
        sif.S_DATA = 8'hFB; sif.S_K = 1'b1;
        step();
        chk("d1_data", 32'(TXDATA), 32'hFB);
        chk("d1_k",    32'(TXDATAK), 32'd1);
        sif.S_VALID = 1'b0;
        step();
        chk("d2_idle", 32'(TXDATA), 32'h7C);
        chk("d2_k",    32'(TXDATAK), 32'd1);

        // Loopback for 5 cycles; the symbol accepted with the request still goes out.
        LOOPB_REQ = 1'b1; sif.S_VALID = 1'b1; sif.S_DATA = 8'hA5; sif.S_K = 1'b0;
        step();
        chk("lb_state",   32'(STATE),   32'd5);
        chk("lb_last_d",  32'(TXDATA),  32'hA5);
        chk("lb_rxl_lag", 32'(RXLOOPB), 32'd0);
        n_lo = sif.S_READY ? 0 : 1;
        sif.S_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!sif.S_READY) n_lo++;
        end
        chk("lb_rxloopb", 32'(RXLOOPB), 32'd1);
        chk("lb_idle",    32'(TXDATA),  32'h7C);
        LOOPB_REQ = 1'b0;
        step();
        chk("lb_ready_lo", 32'(n_lo),  32'd5);
        chk("lb_back",     32'(STATE), 32'd4);
        chk("lb_sready",   32'(sif.S_READY), 32'd1);
        step();
        chk("lb_rxl_off",  32'(RXLOOPB), 32'd0);

        // Asynchronous reset in ACTIVE takes effect without a clock edge.
        RXDET_O = 1'b0; COMP_REQ = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        chk("ar_state",  32'(STATE),  32'd0);
        chk("ar_txidle", 32'(TXIDLE), 32'd1);
        chk("ar_linkup", 32'(LINK_UP), 32'd0);
        chk("ar_sready", 32'(sif.S_READY), 32'd0);
        step(); step();
        RESET_N = 1'b1;

        // No receiver, no compliance request: FAIL after 4 + 16 cycles.
        for (int i = 0; i < 20; i++) step();
        chk("f_wait",    32'(STATE),    32'd2);
        step();
        chk("f_state",   32'(STATE),    32'd7);
        step();
        chk("f_detfail", 32'(DET_FAIL), 32'd1);
        chk("f_txidle",  32'(TXIDLE),   32'd1);
        ENABLE = 1'b0;
        step();
        chk("f_off",     32'(STATE),    32'd0);
        chk("f_lag",     32'(DET_FAIL), 32'd1);
        step();
        chk("f_clear",   32'(DET_FAIL), 32'd0);

        // Same with compliance requested: alternating BC/K and B5/D.
        COMP_REQ = 1'b1; ENABLE = 1'b1;
        for (int i = 0; i < 21; i++) step();
        chk("c_state", 32'(STATE), 32'd6);
        step();
        chk("c_comp",  32'(TXCOMP), 32'd1);
        chk("c_s0",    32'({TXDATAK, TXDATA}), 32'h1BC);
        step();
        chk("c_s1",    32'({TXDATAK, TXDATA}), 32'h0B5);
        step();
        chk("c_s2",    32'({TXDATAK, TXDATA}), 32'h1BC);
        ENABLE = 1'b0;
        step();
        chk("c_off",   32'(STATE),  32'd0);
        step();
        chk("c_clear", 32'(TXCOMP), 32'd0);
        chk("c_idle",  32'(TXIDLE), 32'd1);

        // ENABLE dropped during TRAIN.
        COMP_REQ = 1'b0; RXDET_O = 1'b1; ENABLE = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("t_state", 32'(STATE), 32'd3);
        step(); step();
        chk("t_comma", 32'({TXDATAK, TXDATA}), 32'h1BC);
        ENABLE = 1'b0;
        step();
        chk("t_off",    32'(STATE),  32'd0);
        chk("t_lag",    32'(TXIDLE), 32'd0);
        step();
        chk("t_idle",   32'(TXIDLE), 32'd1);
        chk("t_data",   32'({TXDATAK, TXDATA}), 32'h000);

`ifdef SKP_INSERT_EN
        begin
            int   skips;
            int   bad;
            logic rdy;
            logic [7:0] d;
            skips = 0; bad = 0; d = 8'h00;
            bring_up(n_rxdet, n_comma);
            chk("s_up", 32'(LINK_UP), 32'd1);
            sif.S_VALID = 1'b1; sif.S_K = 1'b0;
            for (int i = 0; i < 130; i++) begin
                sif.S_DATA = d;
                rdy = sif.S_READY;
                step();
                if (rdy) begin
                    if (TXDATA !== d || TXDATAK !== 1'b0) bad++;
                    d = d + 8'd1;
                end else begin
                    if (TXDATA !== 8'h1C || TXDATAK !== 1'b1) bad++;
                    skips++;
                end
            end
            sif.S_VALID = 1'b0;
            chk("s_skips", 32'(skips), 32'd2);
            chk("s_bad",   32'(bad),   32'd0);
            chk("s_sent",  32'(d),     32'd128);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
